// File: rtl/vecmac_seq.sv
// -----------------------------------------------------------------------------
// vecmac_seq
//
// Purpose:
//   Sequences an 8-bit dot product through one shared external 4x4 multiplier.
//   Each operand pair is split into four nibble products. Each nibble product
//   is issued to the multiplier, shifted into a 16-bit product register, and
//   the finished product is added into the vector accumulator. When the pair
//   flagged "last" has been accumulated, the result is offered to the sink
//   and held until it is accepted.
//
// Build option:
//   VECMAC_SIGNED_EN  defined   -> operands are two's-complement int8. The
//                                  nibble products are formed on magnitudes,
//                                  the product is negated when the operand
//                                  signs differ, and out_ovf flags signed
//                                  overflow.
//                     undefined -> operands are unsigned 0..255 and out_ovf
//                                  flags carry-out of the accumulator.
//
// Parameters:
//   ACC_W       accumulator width (>= 17)
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          operand pair handshake
//   in_a, in_b, in_last        operand pair and end-of-vector marker
//   out_valid/out_ready        result handshake
//   out_acc, out_ovf           accumulator and sticky overflow flag
//   mul_start, mul_a, mul_b    start pulse and nibble operands to the multiplier
//   mul_out, mul_finish        product and one-cycle done pulse from the multiplier
// -----------------------------------------------------------------------------
module vecmac_seq #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             mul_start,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_out,
    input  logic             mul_finish
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_ovf;
    logic             r_mul_start;
    logic             r_last;
    logic [ACC_W-1:0] r_acc;
    logic [15:0]      r_prod;
    logic [1:0]       r_k;
    logic [7:0]       r_a_mag;
    logic [7:0]       r_b_mag;
    logic [3:0]       r_mul_a;
    logic [3:0]       r_mul_b;
`ifdef VECMAC_SIGNED_EN
    logic             r_neg;
`endif

    logic [7:0]       w_a_mag;
    logic [7:0]       w_b_mag;
    logic [1:0]       w_k_next;
    logic [7:0]       w_nib_next;
    logic [ACC_W:0]   w_acc_res;

    // Nibble pair for step k: (aL,bL), (aL,bH), (aH,bL), (aH,bH).
    function automatic logic [7:0] nib_sel(input logic [1:0] k,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [3:0] na;
        logic [3:0] nb;
        na = k[1] ? a[7:4] : a[3:0];
        nb = k[0] ? b[7:4] : b[3:0];
        return {na, nb};
    endfunction

    // Weight a partial product: shift 0, 4, 4, 8 for k = 0..3.
    function automatic logic [15:0] part_prod(input logic [7:0] p,
                                              input logic [1:0] k);
        logic [15:0] res;
        case (k)
            2'd0:    res = {8'h00, p};
            2'd3:    res = {p, 8'h00};
            default: res = {4'h0, p, 4'h0};
        endcase
        return res;
    endfunction

`ifdef VECMAC_SIGNED_EN
    // |x| for int8; -128 maps to 8'h80, which reads as 128 unsigned.
    function automatic logic [7:0] mag8(input logic [7:0] x);
        return x[7] ? (~x + 8'd1) : x;
    endfunction

    // Signed wrap-around add; MSB of the result is the overflow flag.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [15:0]      mag,
                                               input logic             neg);
        logic signed [ACC_W-1:0] addend;
        logic signed [ACC_W-1:0] sum;
        logic                    ovf;
        addend = ACC_W'(mag);
        if (neg) begin
            addend = -addend;
        end
        sum = $signed(acc) + addend;
        ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        return {ovf, sum};
    endfunction

    assign w_a_mag   = mag8(in_a);
    assign w_b_mag   = mag8(in_b);
    assign w_acc_res = acc_add(r_acc, r_prod, r_neg);
`else
    // Unsigned add; MSB of the result is the carry-out.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [15:0]      mag);
        logic [ACC_W-1:0] addend;
        addend = ACC_W'(mag);
        return {1'b0, acc} + {1'b0, addend};
    endfunction

    assign w_a_mag   = in_a;
    assign w_b_mag   = in_b;
    assign w_acc_res = acc_add(r_acc, r_prod);
`endif

    assign w_k_next   = r_k + 2'd1;
    assign w_nib_next = nib_sel(w_k_next, r_a_mag, r_b_mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_mul_start <= 1'b0;
            r_last      <= 1'b0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_k         <= '0;
            r_a_mag     <= '0;
            r_b_mag     <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
`ifdef VECMAC_SIGNED_EN
            r_neg       <= 1'b0;
`endif
        end else begin
            // Start is a single-cycle pulse raised only on entry to ISSUE.
            r_mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a_mag     <= w_a_mag;
                        r_b_mag     <= w_b_mag;
                        r_last      <= in_last;
`ifdef VECMAC_SIGNED_EN
                        r_neg       <= in_a[7] ^ in_b[7];
`endif
                        r_k         <= 2'd0;
                        r_prod      <= '0;
                        r_mul_a     <= w_a_mag[3:0];
                        r_mul_b     <= w_b_mag[3:0];
                        r_mul_start <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_finish) begin
                        r_prod <= r_prod + part_prod(mul_out, r_k);
                        if (r_k != 2'd3) begin
                            r_k         <= w_k_next;
                            r_mul_a     <= w_nib_next[7:4];
                            r_mul_b     <= w_nib_next[3:0];
                            r_mul_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_acc_res[ACC_W-1:0];
                    if (w_acc_res[ACC_W]) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;

endmodule

// File: tb/tb_vecmac_seq.sv
// -----------------------------------------------------------------------------
// tb_vecmac_seq
//
// Bench for vecmac_seq with a behavioural 4x4 multiplier and a dot-product
// model built from plain integer arithmetic. Works for both builds
// (VECMAC_SIGNED_EN defined or not). ACC_W is 17 so that overflow is reachable.
// -----------------------------------------------------------------------------
module tb_vecmac_seq;

    localparam int ACC_W = 17;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic             mul_start;
    logic [3:0]       mul_a;
    logic [3:0]       mul_b;
    logic [7:0]       mul_out;
    logic             mul_finish;

    vecmac_seq #(.ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_ovf    (out_ovf),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_out    (mul_out),
        .mul_finish (mul_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- dot-product model ----------------
    longint           mdl_acc;
    bit               mdl_ovf;
    logic [ACC_W-1:0] mdl_bits;

    task automatic mdl_clear();
        mdl_acc  = 0;
        mdl_ovf  = 0;
        mdl_bits = '0;
    endtask

    task automatic mdl_step(input logic [7:0] a, input logic [7:0] b);
        longint p;
        longint span;
        span = longint'(1) << ACC_W;
`ifdef VECMAC_SIGNED_EN
        p = longint'($signed(a)) * longint'($signed(b));
        mdl_acc = mdl_acc + p;
        if (mdl_acc > (span / 2) - 1) begin
            mdl_ovf = 1;
            mdl_acc = mdl_acc - span;
        end else if (mdl_acc < -(span / 2)) begin
            mdl_ovf = 1;
            mdl_acc = mdl_acc + span;
        end
`else
        p = longint'(a) * longint'(b);
        mdl_acc = mdl_acc + p;
        if (mdl_acc >= span) begin
            mdl_ovf = 1;
            mdl_acc = mdl_acc - span;
        end
`endif
        mdl_bits = mdl_acc[ACC_W-1:0];
    endtask

    // ---------------- external 4x4 multiplier ----------------
    // Start sampled at edge E -> finish high for the cycle after E+4.
    bit spur_req;
    initial begin : mult_model
        logic       s_start;
        logic       s_rst;
        bit         s_spur;
        logic [3:0] s_a;
        logic [3:0] s_b;
        logic [3:0] m_a;
        logic [3:0] m_b;
        int         m_cnt;
        mul_finish = 1'b0;
        mul_out    = 8'h00;
        m_cnt      = 0;
        m_a        = 4'h0;
        m_b        = 4'h0;
        forever begin
            @(negedge clk);
            s_start = mul_start;
            s_rst   = rst;
            s_a     = mul_a;
            s_b     = mul_b;
            s_spur  = spur_req;
            @(posedge clk);
            #1;
            mul_finish = 1'b0;
            mul_out    = 8'($urandom);
            if (s_rst) begin
                m_cnt = 0;
            end else if (s_start) begin
                m_cnt = 4;
                m_a   = s_a;
                m_b   = s_b;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    mul_finish = 1'b1;
                    mul_out    = {4'h0, m_a} * {4'h0, m_b};
                end
            end
            if (s_spur) begin
                spur_req   = 0;
                mul_finish = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            check("out_acc_vs_model", out_acc, mdl_bits);
            check("out_ovf_vs_model", out_ovf, mdl_ovf);
            check("in_ready_low_in_done", in_ready, 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] mag_of(input logic [7:0] x);
`ifdef VECMAC_SIGNED_EN
        return x[7] ? 8'(-x) : x;
`else
        return x;
`endif
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last);
        int         n;
        int         starts;
        int         pos[4];
        int         lat;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [3:0] xa;
        logic [3:0] xb;
        ea = mag_of(a);
        eb = mag_of(b);
        for (int i = 0; i < 4; i++) pos[i] = 0;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mdl_step(a, b);
        starts = 0;
        lat    = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            // offer junk while busy; it must be ignored
            if (c == 3) begin
                in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_last = 1'($urandom);
            end
            if (c == 10) in_valid = 1'b0;
            if (mul_start === 1'b1) begin
                if (starts < 4) begin
                    pos[starts] = c;
                    xa = (starts >= 2) ? ea[7:4] : ea[3:0];
                    xb = (starts == 1 || starts == 3) ? eb[7:4] : eb[3:0];
                    check("mul_a_nibble", mul_a, xa);
                    check("mul_b_nibble", mul_b, xb);
                end
                starts++;
            end
            if (in_ready === 1'b1 || out_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        in_valid = 1'b0;
        check("response_latency", lat, 26);
        check("mul_start_count", starts, 4);
        for (int k = 0; k < 4; k++) check("mul_start_cycle", pos[k], 1 + 6 * k);
        check("resp_out_valid", out_valid, last);
        check("resp_in_ready", in_ready, !last);
    endtask

    task automatic finish_vec(input longint exp_acc, input bit exp_ovf, input int hold);
        logic [ACC_W-1:0] v;
        check("result_acc", out_acc, exp_acc);
        check("result_ovf", out_ovf, exp_ovf);
        v = out_acc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_acc", out_acc, v);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        mdl_clear();
        @(negedge clk);
        check("after_ack_out_valid", out_valid, 0);
        check("after_ack_acc", out_acc, 0);
        check("after_ack_ovf", out_ovf, 0);
        check("after_ack_in_ready", in_ready, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_acc"},   out_acc, 0);
        check({tag, "_out_ovf"},   out_ovf, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_a"},     mul_a, 0);
        check({tag, "_mul_b"},     mul_b, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int saw_valid;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        out_ready = 1'b0; spur_req = 0;
        mdl_clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", in_ready, 1);

`ifdef VECMAC_SIGNED_EN
        send(8'h80, 8'h80, 0);              // -128 * -128 = 16384
        send(8'hFF, 8'd127, 1);             // -1 * 127 = -127
        finish_vec(16257, 0, 0);
        send(8'hFB, 8'd7, 1);               // -35 -> 131072-35
        finish_vec(131037, 0, 0);
        send(8'd127, 8'h80, 1);             // -16256 -> 131072-16256
        finish_vec(114816, 0, 0);
        for (int i = 0; i < 5; i++) send(8'h80, 8'h80, i == 4);
        finish_vec(81920, 1, 0);            // 81920 wraps to -49152
        send(8'd1, 8'd1, 1);
        finish_vec(1, 0, 0);
`else
        send(8'd200, 8'd100, 1);
        finish_vec(20000, 0, 0);
        send(8'd255, 8'd255, 0);
        send(8'd1, 8'd1, 0);
        send(8'd0, 8'd77, 1);
        finish_vec(65026, 0, 0);
        for (int i = 0; i < 3; i++) send(8'd255, 8'd255, i == 2);
        finish_vec(64003, 1, 0);            // 195075 mod 131072
        send(8'd1, 8'd1, 1);
        finish_vec(1, 0, 0);
`endif

        // backpressure, then a stray multiplier done pulse while idle
        send(8'd12, 8'd13, 1);
        finish_vec(156, 0, 10);
        spur_req = 1;
        repeat (3) @(posedge clk);
        #1;
        send(8'd2, 8'd3, 1);
        finish_vec(6, 0, 0);

        // abort mid-vector during WAIT of nibble k=2
        send(8'd9, 8'd9, 0);
        @(negedge clk);
        in_a = 8'd200; in_b = 8'd100; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_clear();
        check_reset_values("midop_reset");
        saw_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid++;
        end
        check("no_valid_after_abort", saw_valid, 0);
        send(8'd3, 8'd4, 1);
        finish_vec(12, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vecmac_seq.md
# vecmac_seq

Sequencer that computes an int8 dot product on one shared 4x4 shift-and-add multiplier. It takes a stream of 8-bit operand pairs and splits each 8x8 product into four nibble products. Each nibble product is issued to the external 4x4 multiplier, and the partial products are shifted and accumulated. The block sits between the vector operand feeder and the result sink, and owns the multiplier's `start`/operand inputs.

## Interface
- `ACC_W`, default 20: accumulator width in bits. Must be ≥ 17.
- `clk`, input, 1: clock. Everything is on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high. Also wired to the multiplier's reset.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: block can accept a pair.
- `in_a`, input, 8: operand A.
- `in_b`, input, 8: operand B.
- `in_last`, input, 1: this pair is the final element of the vector.
- `out_valid`, output, 1: dot-product result valid.
- `out_ready`, input, 1: sink accepts the result.
- `out_acc`, output, ACC_W: accumulated result.
- `out_ovf`, output, 1: sticky overflow flag for this vector.
- `mul_start`, output, 1: one-cycle start pulse to the multiplier.
- `mul_a`, output, 4: multiplier nibble operand A.
- `mul_b`, output, 4: multiplier nibble operand B.
- `mul_out`, input, 8: multiplier product.
- `mul_finish`, input, 1: multiplier done pulse, high for exactly one cycle.

## Operation
- **States:** IDLE, ISSUE, WAIT, ACCUM, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch the operand magnitudes and `in_last`, set nibble index k=0, clear the 16-bit product register `prod`, go to ISSUE.
- **ISSUE**
  - `mul_start`=1 for exactly this cycle; go to WAIT.
  - `mul_a`/`mul_b` are registered and stable from ISSUE through WAIT.
  - Nibble order, with shifts:
    - k=0: (aL,bL), shift 0
    - k=1: (aL,bH), shift 4
    - k=2: (aH,bL), shift 4
    - k=3: (aH,bH), shift 8
- **WAIT**
  - Holds until `mul_finish`=1.
  - In that cycle: `prod` += `mul_out` << shift(k).
  - If k<3: k++, go to ISSUE. Otherwise go to ACCUM.
- **ACCUM**
  - acc ← acc + product, modulo 2^ACC_W.
  - Set `out_ovf` on carry-out (unsigned build) or two's-complement overflow (signed build).
  - If the latched last flag is set, go to DONE; otherwise go to IDLE.
- **DONE**
  - `out_valid`=1, with `out_acc`/`out_ovf` held stable.
  - On `out_ready`: clear acc and `out_ovf`, go to IDLE.
- **Ignored inputs:**
  - `in_valid` outside IDLE.
  - `mul_finish` outside WAIT.
- **Output drive:** `out_acc` shows the running accumulator at all times. It is only meaningful while `out_valid`=1.

## Timing
- **Reset values:**
  - `in_ready`=0 during the reset cycle, then 1 in IDLE.
  - `out_valid`=0, `out_acc`=0, `out_ovf`=0.
  - `mul_start`=0, `mul_a`=0, `mul_b`=0.
  - State returns to IDLE.
- **Reset mid-operation:** `rst` in any state aborts the vector and clears accumulator, `prod`, k and flags. No partial result is emitted.
- **Multiplier latency:** start sampled at edge E; `mul_finish` visible in the cycle after E+4.
- **Per-element schedule** (pair accepted at edge E0):
  - Nibble k: ISSUE in the cycle after E(6k).
  - Its product is captured at edge E(6k+6).
  - Accumulator is updated at E25.
- **Result and throughput:**
  - `in_ready` or `out_valid` goes high in the cycle after E25.
  - Throughput is one element per 26 cycles.
- **Backpressure:** DONE holds indefinitely, and `in_ready`=0 while in DONE.

## Configuration
- Macro: `VECMAC_SIGNED_EN`.
- **Defined:**
  - `in_a`/`in_b` are two's-complement int8.
  - Magnitudes are taken; |−128| = 128 fits in 8 bits.
  - The product is negated when the signs differ.
  - Accumulation is signed; `out_acc` is two's complement.
  - `out_ovf` flags signed overflow.
- **Undefined:**
  - Operands are unsigned 0–255, with no magnitude or negation logic.
  - Accumulation is unsigned; `out_ovf` flags carry-out.

## Test plan
- **Single element, unsigned:** (200,100,last) → `out_valid` in the cycle after E25, `out_acc`=20000, `out_ovf`=0; exactly four `mul_start` pulses, 6 cycles apart.
- **Three-element vector, unsigned:** (255,255), (1,1), (0,77,last) → `out_acc`=65026. No `out_valid` before the last element. `in_ready` low for 26 cycles after each accept.
- **Backpressure:** `out_ready` held low for 10 cycles in DONE → `out_valid` stays high, value stable, `in_ready`=0. After the handshake, the next vector (2,3,last) → 6, confirming the accumulator cleared.
- **Overflow, ACC_W=17, unsigned:** 3×(255,255), last on the third → `out_acc`=64003 (195075 mod 131072), `out_ovf`=1. The next vector gives `out_ovf`=0.
- **Signed** (`VECMAC_SIGNED_EN` defined):
  - (−128,−128), (−1,127,last) → 16257.
  - (−5,7,last) → −35.
  - (127,−128,last) → −16256.
- **Reset mid-operation:** assert `rst` for one cycle during WAIT of nibble k=2 → all outputs reach reset values the next cycle and no `out_valid` appears. A fresh vector (3,4,last) → 12.
